// File: rtl/flappy_game_ctrl.sv
// Game-flow sequencer for the bird datapath: game FSM, countdown/death timers,
// BCD score with best-score tracking, and gating of the bird/pipe controls.
module flappy_game_ctrl #(
  parameter int unsigned READY_TICKS = 30,
  parameter int unsigned DEATH_TICKS = 20,
  parameter logic [9:0]  FLOOR_Y     = 10'd465
) (
  input  logic       clk10,
  input  logic       clr,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic [9:0] bird_y_pos,
  input  logic       hit,
  input  logic       pipe_pass,
  output logic       bird_clr_n,
  output logic       game_end,
  output logic       up_o,
  output logic       down_o,
  output logic       pipe_run,
  output logic [2:0] state,
  output logic [5:0] cnt,
  output logic [7:0] score,
  output logic [7:0] best
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned SCORE_W = 8;

  localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_TICKS - 1);
  localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SCORE_W-1:0]   score_q;
  logic [SCORE_W-1:0]   best_q;
  logic                 start_q;

  logic                 start_rise;
  logic                 floor_hit;
  logic [SCORE_W-1:0]   score_inc;

  assign start_rise = start & ~start_q;
  assign floor_hit  = (bird_y_pos >= FLOOR_Y);

  // Two-digit BCD increment that saturates at 99.
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'h99) begin
      if (score_q[3:0] == 4'd9) begin
        score_inc = {score_q[7:4] + 4'd1, 4'd0};
      end else begin
        score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk10 or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      best_q  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_q <= ST_READY;
            cnt_q   <= READY_LOAD;
            score_q <= '0;
          end
        end
        ST_READY: begin
          if (cnt_q == '0) begin
            state_q <= ST_PLAY;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // A crash takes priority over a simultaneous pipe pass.
          if (hit || floor_hit) begin
            state_q <= ST_DYING;
            cnt_q   <= DEATH_LOAD;
          end else if (pipe_pass) begin
            score_q <= score_inc;
          end
        end
        ST_DYING: begin
          if (floor_hit || (cnt_q == '0)) begin
            state_q <= ST_OVER;
            if (score_q > best_q) begin
              best_q <= score_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Control outputs decode straight from the registered state.
  always_comb begin
    bird_clr_n = 1'b1;
    game_end   = 1'b1;
    pipe_run   = 1'b0;
    up_o       = 1'b0;
    down_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bird_clr_n = 1'b0;
      end
      ST_PLAY: begin
        game_end = 1'b0;
        pipe_run = 1'b1;
        up_o     = up;
        down_o   = down;
      end
      ST_DYING: begin
        game_end = 1'b0;
        down_o   = 1'b1;
      end
      ST_READY, ST_OVER: begin
        game_end = 1'b1;
      end
      default: begin
        bird_clr_n = 1'b0;
      end
    endcase
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign score = score_q;
  assign best  = best_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: the driver queues expected outputs per
// step, a monitor pops and compares them on the falling edge (or on demand).
module tb_flappy_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic       clk10 = 1'b0;
  logic       clr;
  logic       start;
  logic       up;
  logic       down;
  logic [9:0] bird_y_pos;
  logic       hit;
  logic       pipe_pass;
  logic       bird_clr_n;
  logic       game_end;
  logic       up_o;
  logic       down_o;
  logic       pipe_run;
  logic [2:0] state;
  logic [5:0] cnt;
  logic [7:0] score;
  logic [7:0] best;

  flappy_game_ctrl dut (
    .clk10      (clk10),
    .clr        (clr),
    .start      (start),
    .up         (up),
    .down       (down),
    .bird_y_pos (bird_y_pos),
    .hit        (hit),
    .pipe_pass  (pipe_pass),
    .bird_clr_n (bird_clr_n),
    .game_end   (game_end),
    .up_o       (up_o),
    .down_o     (down_o),
    .pipe_run   (pipe_run),
    .state      (state),
    .cnt        (cnt),
    .score      (score),
    .best       (best)
  );

  always #5 clk10 = ~clk10;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] cnt;
    logic       cnt_ok;
    logic [7:0] score;
    logic [7:0] best;
    logic       clr_n;
    logic       gend;
    logic       upo;
    logic       dno;
    logic       prun;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  sample_ev;

  int vectors = 0;
  int miscmp  = 0;

  logic [2:0] e_state;
  logic [5:0] e_cnt;
  logic       e_cnt_ok;
  logic [7:0] e_score;
  logic [7:0] e_best;

  function automatic logic [7:0] to_bcd(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return 8'((m / 10) * 16 + (m % 10));
  endfunction

  // Expected output decode per state, taken from the state table.
  function automatic void push(input string nm);
    exp_t e;
    e.st     = e_state;
    e.cnt    = e_cnt;
    e.cnt_ok = e_cnt_ok;
    e.score  = e_score;
    e.best   = e_best;
    e.clr_n  = (e_state != S_IDLE);
    e.gend   = (e_state == S_IDLE) || (e_state == S_READY) || (e_state == S_OVER);
    e.prun   = (e_state == S_PLAY);
    e.upo    = (e_state == S_PLAY) ? up : 1'b0;
    e.dno    = (e_state == S_PLAY) ? down : (e_state == S_DYING);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  task automatic tick(input string nm);
    @(posedge clk10);
    #1;
    push(nm);
    @(negedge clk10);
    #1;
  endtask

  function automatic void chk(input string nm, input string f,
                              input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      miscmp++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, f, got, want, $time);
    end
  endfunction

  always begin
    @(negedge clk10 or sample_ev);
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      vectors++;
      chk(nm, "state", 8'(state), 8'(e.st));
      if (e.cnt_ok) chk(nm, "cnt", 8'(cnt), 8'(e.cnt));
      chk(nm, "score", score, e.score);
      chk(nm, "best", best, e.best);
      chk(nm, "bird_clr_n", 8'(bird_clr_n), 8'(e.clr_n));
      chk(nm, "game_end", 8'(game_end), 8'(e.gend));
      chk(nm, "up_o", 8'(up_o), 8'(e.upo));
      chk(nm, "down_o", 8'(down_o), 8'(e.dno));
      chk(nm, "pipe_run", 8'(pipe_run), 8'(e.prun));
    end
  end

  // Start press, 30-tick countdown with held/re-pressed start, then PLAY.
  task automatic start_game();
    start    = 1'b1;
    e_state  = S_READY;
    e_cnt    = 6'd29;
    e_cnt_ok = 1'b1;
    e_score  = 8'h00;
    tick("ready_enter");
    for (int i = 1; i <= 29; i++) begin
      start = (i == 1) || (i == 3);
      e_cnt = 6'(29 - i);
      tick("ready_cnt");
    end
    start   = 1'b0;
    e_state = S_PLAY;
    tick("play_enter");
  endtask

  initial begin
    clr        = 1'b1;
    start      = 1'b0;
    up         = 1'b0;
    down       = 1'b0;
    bird_y_pos = 10'd200;
    hit        = 1'b0;
    pipe_pass  = 1'b0;
    e_state    = S_IDLE;
    e_cnt      = 6'd0;
    e_cnt_ok   = 1'b1;
    e_score    = 8'h00;
    e_best     = 8'h00;
    #2;
    push("reset");
    ->sample_ev;
    @(negedge clk10);
    #1;
    clr = 1'b0;

    // Game 1: score 5, hit with simultaneous pass, death timeout.
    up = 1'b1;
    tick("idle_gate_up");
    up = 1'b0;
    start_game();
    up = 1'b1;
    tick("play_up");
    up   = 1'b0;
    down = 1'b1;
    tick("play_down");
    down = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pipe_pass = 1'b1;
      e_score   = to_bcd(k);
      tick("pass_to_5");
    end
    hit       = 1'b1;
    up        = 1'b1;
    e_state   = S_DYING;
    e_cnt     = 6'd19;
    tick("hit_and_pass");
    hit       = 1'b0;
    pipe_pass = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      pipe_pass = (i == 2);
      start     = (i == 4);
      e_cnt     = 6'(19 - i);
      tick("dying_cnt");
    end
    pipe_pass = 1'b0;
    start     = 1'b0;
    up        = 1'b0;
    e_state   = S_OVER;
    e_best    = 8'h05;
    tick("dying_timeout");
    tick("over_hold");
    start   = 1'b1;
    e_state = S_IDLE;
    tick("over_to_idle");
    for (int i = 0; i < 3; i++) tick("idle_start_held");
    start = 1'b0;
    tick("idle_release");

    // Game 2: score 3, floor contact in PLAY and again in DYING.
    start_game();
    for (int k = 1; k <= 3; k++) begin
      pipe_pass = 1'b1;
      e_score   = to_bcd(k);
      tick("pass_to_3");
    end
    pipe_pass  = 1'b0;
    bird_y_pos = 10'd465;
    e_state    = S_DYING;
    e_cnt      = 6'd19;
    tick("floor_in_play");
    e_state  = S_OVER;
    e_cnt_ok = 1'b0;
    tick("floor_in_dying");
    bird_y_pos = 10'd464;
    tick("over_best_kept");
    start   = 1'b1;
    e_state = S_IDLE;
    tick("over_to_idle2");
    start = 1'b0;
    tick("idle2");

    // Game 3: BCD carry and saturation, then asynchronous clear mid-PLAY.
    bird_y_pos = 10'd200;
    start_game();
    for (int k = 1; k <= 101; k++) begin
      pipe_pass = 1'b1;
      e_score   = to_bcd(k);
      tick((k == 12) ? "score_12" : (k >= 99) ? "score_sat" : "pass");
    end
    pipe_pass = 1'b0;
    tick("play_idle");
    clr     = 1'b1;
    #1;
    e_state = S_IDLE;
    e_cnt   = 6'd0;
    e_score = 8'h00;
    e_best  = 8'h00;
    push("clr_async");
    ->sample_ev;
    #1;
    clr = 1'b0;
    tick("after_clr");

    @(negedge clk10);
    #1;
    if (exp_q.size() != 0) begin
      miscmp++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Top-level game-flow sequencer for the bird datapath: owns the game state machine, drives the bird position register's active-low clear and freeze (game_end), gates the up/down buttons, and forces the death fall.
- Keeps a 2-digit BCD score from pipe-pass pulses and a best-score register.
- Sits between the button/collision logic and the bird position register; also enables pipe scrolling.

Parameters:
- READY_TICKS, 30, clk10 ticks of frozen countdown before play (3 s at 10 Hz); range 1..63.
- DEATH_TICKS, 20, maximum ticks of forced fall after a crash; range 1..63.
- FLOOR_Y, 10'd465, bird_y_pos at or above this value counts as ground contact.

Ports:
- clk10, in, 1: 10 Hz game tick clock.
- clr, in, 1: asynchronous, active-high reset.
- start, in, 1: start button level, synchronous to clk10.
- up, in, 1: raw up button.
- down, in, 1: raw down button.
- bird_y_pos, in, 10: current bird vertical position.
- hit, in, 1: pipe collision level.
- pipe_pass, in, 1: one-cycle pulse when a pipe passes the bird.
- bird_clr_n, out, 1: active-low clear to the bird position register.
- game_end, out, 1: freezes bird movement when 1.
- up_o, out, 1: gated up to the bird position register.
- down_o, out, 1: gated down to the bird position register.
- pipe_run, out, 1: pipe scroll enable.
- state, out, 3: IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4.
- cnt, out, 6: tick counter value.
- score, out, 8: two BCD digits, [7:4] tens.
- best, out, 8: best score, BCD.

Behaviour:
- Reset (clr=1, async): state=IDLE, cnt=0, score=8'h00, best=8'h00, start_q=0. Outputs take their IDLE decode immediately.
- start_rise = start & ~start_q. start_q is registered every clk10. Only rising edges act; a held button does not repeat.
- Outputs are a pure decode of the registered state, so they change on the same edge as state.
  - IDLE: bird_clr_n=0, game_end=1, pipe_run=0.
  - READY: bird_clr_n=1, game_end=1, pipe_run=0.
  - PLAY: bird_clr_n=1, game_end=0, pipe_run=1, up_o=up, down_o=down.
  - DYING: bird_clr_n=1, game_end=0, pipe_run=0, up_o=0, down_o=1.
  - OVER: bird_clr_n=1, game_end=1, pipe_run=0.
  - up_o and down_o are 0 in every state except PLAY and DYING.
- IDLE: on start_rise, go to READY, set cnt=READY_TICKS-1, clear score to 0.
- READY:
  - If cnt==0, go to PLAY; otherwise cnt decrements.
  - start_rise is ignored.
  - Latency from start_rise to PLAY is READY_TICKS+1 edges.
- PLAY:
  - If hit=1 or bird_y_pos>=FLOOR_Y, go to DYING and set cnt=DEATH_TICKS-1.
  - Else on pipe_pass, increment score in BCD (09->10, 19->20), saturating at 99.
  - hit and pipe_pass in the same cycle: hit wins and score is not incremented.
  - cnt holds its value.
- DYING:
  - If bird_y_pos>=FLOOR_Y or cnt==0, go to OVER; otherwise cnt decrements.
  - pipe_pass and start_rise are ignored.
- Entering OVER (the DYING->OVER edge): if score>best (plain unsigned compare, which is valid for BCD), best<=score on that same edge.
- OVER: on start_rise, go to IDLE. The bird is held cleared for at least 1 cycle; a further start_rise is needed to play again.
- score holds its value in OVER and IDLE until the next IDLE->READY edge.
- Illegal state codes 5..7 go to IDLE on the next edge.
- Reset asserted mid-game returns to IDLE asynchronously and clears best.

Test Plan:
- Reset then start pulse: state 0->1 on the edge after start rises; game_end=1 and bird_clr_n=1 during READY; state=2 exactly 31 edges after the start edge (READY_TICKS=30); game_end=0.
- In PLAY, 12 pipe_pass pulses: score=8'h12. Then 88 more: score=8'h99 and stays 8'h99 on a further pulse.
- PLAY, hit and pipe_pass asserted together with score 8'h05: state=3 next edge, score stays 8'h05, up_o=0 and down_o=1 while up is held.
- DYING with bird_y_pos stuck at 200: OVER after 20 edges, best=score. DYING with bird_y_pos=465: OVER on the next edge.
- Second game scoring 8'h03 after best=8'h05: best stays 8'h05. Start held high across OVER->IDLE: no READY until start is released and pressed again.
- clr pulsed mid-PLAY between edges: state=0, score=0, best=0, bird_clr_n=0 immediately with no clock edge.
